// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for uart_tx_feeder: downstream UART register map,
// STATUS busy bit and the feeder FSM state encoding.
package uart_tx_feeder_pkg;

    localparam logic [31:0] CTRL_OFS        = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS      = 32'h0000_0004;
    localparam logic [31:0] TXDATA_OFS      = 32'h0000_000C;
    localparam int          STATUS_BUSY_BIT = 0;
    localparam logic [31:0] CTRL_TX_EN      = 32'h0000_0001;
    localparam logic [7:0]  LF_BYTE         = 8'h0A;
    localparam logic [7:0]  CR_BYTE         = 8'h0D;

    typedef enum logic [2:0] {
        INIT,
        INIT_RSP,
        IDLE,
        RD_STAT,
        RD_RSP,
        WR_TX,
        WR_RSP
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push alongside a pop is
// accepted even when full, so the occupancy stays unchanged.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and feeds them to a memory-mapped UART, polling STATUS
// before each TXDATA write. Define UART_TX_FEEDER_CRLF_EN to expand LF into CR,LF.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] UART_BASE = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        fifo_empty_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    input  logic [31:0] data_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o
);

    // Bus handshake: a request transfers on a cycle where req_valid_o and
    // req_ready_i are both high, and addr_o/data_o/we_o hold until then;
    // a response transfers when rsp_valid_i and rsp_ready_o are both high.

    state_t     state;
    state_t     next_state;
    logic [7:0] head;
    logic [7:0] tx_byte;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       req_fire;
    logic       rsp_fire;
    logic       lf_pending;
    logic       unused_rdata;

    assign push         = byte_valid_i & byte_ready_o;
    assign byte_ready_o = ~fifo_full;
    assign fifo_empty_o = fifo_empty;
    assign sel_o        = 4'b0001;
    assign req_fire     = req_valid_o & req_ready_i;
    assign rsp_ready_o  = state inside {INIT_RSP, RD_RSP, WR_RSP};
    assign rsp_fire     = rsp_valid_i & rsp_ready_o;
    assign unused_rdata = ^data_i;

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (byte_i),
        .pop  (pop),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

`ifdef UART_TX_FEEDER_CRLF_EN
    // Set once the CR ahead of a head-of-queue LF has gone out.
    logic cr_sent;

    assign lf_pending = (head == LF_BYTE) && !cr_sent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                cr_sent <= 1'b0;
        else if (state == WR_RSP && rsp_fire)   cr_sent <= lf_pending;
    end
`else
    assign lf_pending = 1'b0;
`endif

    assign tx_byte = lf_pending ? CR_BYTE : head;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            INIT:     if (req_fire) next_state = INIT_RSP;
            INIT_RSP: if (rsp_fire) next_state = IDLE;
            IDLE:     if (!fifo_empty) next_state = RD_STAT;
            RD_STAT:  if (req_fire) next_state = RD_RSP;
            RD_RSP:   if (rsp_fire) next_state = data_i[STATUS_BUSY_BIT] ? RD_STAT : WR_TX;
            WR_TX:    if (req_fire) next_state = WR_RSP;
            WR_RSP: begin
                if (rsp_fire) begin
                    next_state = IDLE;
                    pop        = !lf_pending;
                end
            end
            default:  next_state = INIT;
        endcase
    end

    // Request fields load only while no request is on the bus, so they
    // cannot move under a stalled request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            req_valid_o <= 1'b0;
            addr_o      <= '0;
            data_o      <= '0;
            we_o        <= 1'b0;
        end else begin
            state       <= next_state;
            req_valid_o <= next_state inside {INIT, RD_STAT, WR_TX};
            if (!req_valid_o || req_fire) begin
                case (next_state)
                    INIT: begin
                        addr_o <= UART_BASE + CTRL_OFS;
                        data_o <= CTRL_TX_EN;
                        we_o   <= 1'b1;
                    end
                    RD_STAT: begin
                        addr_o <= UART_BASE + STATUS_OFS;
                        data_o <= '0;
                        we_o   <= 1'b0;
                    end
                    WR_TX: begin
                        addr_o <= UART_BASE + TXDATA_OFS;
                        data_o <= {24'h0, tx_byte};
                        we_o   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
